pdm_decimator: RTL and testbench
================================

// Module: pdm_decimator
// PURPOSE
//  Downstream of the microphone PDM capture stage. Takes the 1-bit PDM stream plus its per-bit strobe,
//  counts ones over a window of DECIM bits and produces one signed, DC-centred PCM sample per window.
//  Samples are buffered in a small show-ahead FIFO and read out over a valid/ready handshake by the
//  PCM audio consumer. A saturating counter records samples dropped because the FIFO was full.
// PARAMETERS
//  DECIM       16  PDM bits per PCM sample; power of two, 4..256
//  FIFO_DEPTH   4  sample buffer entries; power of two, >=2
//  SW (local)  $clog2(DECIM)+2  sample width; holds -DECIM..+DECIM signed
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous reset, active-high
//  enable        in   1   1 = accumulate; 0 = discard the partial window, keep draining the FIFO
//  dataint       in   1   PDM bit from the capture stage
//  bit_valid     in   1   one-cycle strobe: dataint is valid this cycle
//  sample_data   out  SW  signed PCM sample at the FIFO head
//  sample_valid  out  1   FIFO not empty
//  sample_ready  in   1   consumer accepts sample_data this cycle
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  entries held
//  overrun       out  1   one-cycle pulse: a finished sample was dropped
//  overrun_cnt   out  8   dropped samples, saturates at 255
// BEHAVIOUR
//  - Reset: sample_data=0, sample_valid=0, fifo_level=0, overrun=0, overrun_cnt=0; bit counter and
//    ones accumulator cleared; FIFO pointers cleared. A reset mid-window or with samples queued discards all.
//  - FSM IDLE/ACCUM. IDLE: counters held at 0, strobes ignored; enable=1 -> ACCUM on the next clk.
//    ACCUM: enable=0 -> IDLE on the next clk and the partial window is dropped (no sample is produced).
//  - Bit accepted when state==ACCUM && enable && bit_valid: ones += dataint, bitcnt += 1.
//  - Window end = accepted bit with bitcnt==DECIM-1. On that bit, sample = 2*(ones+dataint) - DECIM,
//    computed in SW-bit two's complement. Push it and clear bitcnt/ones in the same cycle.
//  - Range: 16 ones -> +16, 8 ones -> 0, 0 ones -> -16 (DECIM=16). There is no clipping.
//  - Latency: with the FIFO empty, sample_valid=1 and sample_data is valid on the clk after the last bit.
//  - Pop = sample_valid && sample_ready. sample_data shows the head entry combinationally from the FIFO
//    registers (show-ahead). sample_data holds its value while valid && !ready.
//  - Push with FIFO full and no pop in that cycle: sample dropped, overrun=1 for one clk,
//    overrun_cnt+1 (sticky at 255). Push with full and pop together: both happen, level unchanged, no overrun.
//  - Push and pop on a non-full, non-empty FIFO: level unchanged. A pop on an empty FIFO cannot occur
//    because sample_valid=0.
//  - Pointers wrap modulo FIFO_DEPTH. fifo_level is the exact count, 0..FIFO_DEPTH.
//  - bit_valid with enable=0 has no effect on counters. FIFO reads continue in IDLE.
// STRUCTURE
//  - Package mic_pkg: DECIM_DEF, FIFO_DEPTH_DEF, function sample_w(decim), typedef of the FSM state enum.
//  - Sub-module pcm_sample_fifo (parameters WIDTH, DEPTH): synchronous show-ahead FIFO with
//    push/pop/full/empty/level. The decimator keeps the FSM, accumulator, sample arithmetic and overrun logic.
// TESTING
//  1. Reset 3 clks, then enable=1; feed 16 strobed ones -> one clk after the 16th bit: sample_valid=1, sample_data=+16.
//  2. Pattern 1010.. (16 bits) -> 0. Then 16 zeros -> -16 (6'b110000). Then 12 ones + 4 zeros -> +8; samples in order.
//  3. sample_ready=0, feed 5 windows of ones -> fifo_level=4, overrun pulses once on the 5th window,
//     overrun_cnt=1; draining yields four +16 samples.
//  4. FIFO full, assert sample_ready in the same clk as the window-end bit -> no overrun, level stays 4,
//     the new sample is last out.
//  5. After 7 accepted bits drop enable for 1 clk, then re-enable and feed 16 ones -> exactly one sample, +16.
//  6. With 3 samples queued and a window half done, pulse reset -> next clk: sample_valid=0, fifo_level=0,
//     overrun_cnt=0; the next full window is correct.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared definitions for the microphone PDM-to-PCM decimation path.
//   DECIM_DEF       default PDM bits per PCM sample
//   FIFO_DEPTH_DEF  default sample buffer depth
//   sample_w()      width of a signed sample that spans -decim..+decim
//   state_t         decimator FSM state
package mic_pkg;

  localparam int DECIM_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  // +decim needs $clog2(decim)+1 magnitude bits, plus one bit for the sign.
  function automatic int sample_w(input int decim);
    return $clog2(decim) + 2;
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } state_t;

endpackage

// File: rtl/pcm_sample_fifo.sv
// Synchronous show-ahead FIFO for PCM samples.
//   clk, reset   system clock, synchronous active-high reset
//   push         write push_data (accepted when not full, or when full and popping)
//   push_data    sample to enqueue
//   pop          consume the head entry (ignored when empty)
//   head_data    head entry, combinational from storage; 0 when empty
//   empty, full  occupancy flags
//   level        exact entry count, 0..DEPTH
module pcm_sample_fifo #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Gate the head so an empty FIFO shows 0 rather than stale storage.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by level/pointers, so
  // clearing the array would only add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: counts ones over DECIM strobed PDM bits and emits one
// DC-centred signed sample (2*ones - DECIM) per window into a show-ahead FIFO.
//   clk, reset    system clock, synchronous active-high reset
//   enable        1 = accumulate; 0 = drop the partial window (FIFO still drains)
//   dataint       PDM bit, qualified by bit_valid
//   bit_valid     one-cycle strobe for dataint
//   sample_data   two's-complement sample at the FIFO head
//   sample_valid  FIFO not empty
//   sample_ready  consumer takes sample_data this cycle
//   fifo_level    entries held
//   overrun       one-cycle pulse when a finished sample is dropped
//   overrun_cnt   dropped sample count, saturating at 255
module pdm_decimator
  import mic_pkg::*;
#(
  parameter  int DECIM      = DECIM_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int SW         = sample_w(DECIM),
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          dataint,
  input  logic          bit_valid,
  output logic [SW-1:0] sample_data,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overrun,
  output logic [7:0]    overrun_cnt
);

  localparam int            CW   = $clog2(DECIM);
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  state_t        state;
  logic [CW-1:0] bitcnt;
  logic [CW-1:0] ones;      // at most DECIM-1 before the closing bit
  logic          accept;
  logic          window_end;
  logic          pop;
  logic          drop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [SW-1:0] total;
  logic [SW-1:0] sample_next;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    accept      = 1'b0;
    window_end  = 1'b0;
    total       = '0;
    sample_next = '0;
    accept      = (state == ST_ACCUM) && enable && bit_valid;
    window_end  = accept && (bitcnt == LAST);
    // Include the closing bit itself; the doubled count minus DECIM centres
    // the result on zero and wraps into SW-bit two's complement.
    total       = SW'(ones) + SW'(dataint);
    sample_next = {total[SW-2:0], 1'b0} - SW'(DECIM);
  end

  assign sample_valid = !fifo_empty;
  assign pop          = sample_valid && sample_ready;
  assign drop         = window_end && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      ones        <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          bitcnt <= '0;
          ones   <= '0;
          if (enable) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (!enable) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            ones   <= '0;
          end else if (accept) begin
            if (window_end) begin
              bitcnt <= '0;
              ones   <= '0;
            end else begin
              bitcnt <= bitcnt + CW'(1);
              ones   <= ones + CW'(dataint);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (drop) begin
        overrun <= 1'b1;
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  pcm_sample_fifo #(
    .WIDTH (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (window_end),
    .push_data (sample_next),
    .pop       (sample_ready),
    .head_data (sample_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator (DECIM=16, FIFO_DEPTH=4): table-driven
// windows with hand-computed samples, plus sequences for overrun, full-FIFO
// push/pop, enable drop and mid-window reset.
module tb_pdm_decimator;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       dataint;
  logic       bit_valid;
  logic [5:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic [2:0] fifo_level;
  logic       overrun;
  logic [7:0] overrun_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] bits;   // sent MSB first
    logic [5:0]  exp;
  } vec_t;

  vec_t vec [6];

  always #5 clk = ~clk;

  pdm_decimator #(
    .DECIM      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .dataint      (dataint),
    .bit_valid    (bit_valid),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overrun      (overrun),
    .overrun_cnt  (overrun_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    dataint   = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    dataint   = 1'b0;
  endtask

  // Feed one window; last_ready drives sample_ready alongside the final bit.
  task automatic feed_window(input logic [15:0] bits, input logic last_ready);
    for (int i = 15; i >= 0; i--) begin
      dataint      = bits[i];
      bit_valid    = 1'b1;
      sample_ready = (i == 0) ? last_ready : 1'b0;
      tick();
    end
    bit_valid    = 1'b0;
    dataint      = 1'b0;
    sample_ready = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [5:0] exp);
    check({name, " valid"}, {31'd0, sample_valid}, 32'd1);
    check({name, " data"}, {26'd0, sample_data}, {26'd0, exp});
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
  endtask

  initial begin
    vec[0] = '{bits: 16'hFFFF, exp: 6'd16};      // all ones
    vec[1] = '{bits: 16'hAAAA, exp: 6'd0};       // 8 ones
    vec[2] = '{bits: 16'h0000, exp: 6'b110000};  // -16
    vec[3] = '{bits: 16'hFFF0, exp: 6'd8};       // 12 ones
    vec[4] = '{bits: 16'h000F, exp: 6'b111000};  // 4 ones -> -8
    vec[5] = '{bits: 16'h7FFF, exp: 6'd14};      // 15 ones

    reset        = 1'b1;
    enable       = 1'b0;
    dataint      = 1'b0;
    bit_valid    = 1'b0;
    sample_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset sample_valid", {31'd0, sample_valid}, 32'd0);
    check("reset sample_data", {26'd0, sample_data}, 32'd0);
    check("reset fifo_level", {29'd0, fifo_level}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    check("reset overrun_cnt", {24'd0, overrun_cnt}, 32'd0);

    // Test 1: latency of the first window.
    enable = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    check("t1 valid before last bit", {31'd0, sample_valid}, 32'd0);
    send_bit(1'b1);
    check("t1 level", {29'd0, fifo_level}, 32'd1);
    pop_expect("t1 sample", 6'd16);
    check("t1 empty after pop", {31'd0, sample_valid}, 32'd0);

    // Test 2: table of windows, queued then drained in order.
    for (int i = 0; i < 6; i++) begin
      feed_window(vec[i].bits, 1'b0);
      check($sformatf("t2 level after vec%0d", i), {29'd0, fifo_level}, (i % 4) + 1);
      if ((i % 4) == 3 || i == 5) begin
        for (int j = i - (i % 4); j <= i; j++)
          pop_expect($sformatf("t2 vec%0d", j), vec[j].exp);
        check($sformatf("t2 drained at vec%0d", i), {31'd0, sample_valid}, 32'd0);
      end
    end

    // Test 3: overrun on the fifth window with the consumer stalled.
    for (int w = 0; w < 4; w++) begin
      feed_window(16'hFFFF, 1'b0);
      check($sformatf("t3 overrun win%0d", w), {31'd0, overrun}, 32'd0);
    end
    check("t3 level full", {29'd0, fifo_level}, 32'd4);
    feed_window(16'hFFFF, 1'b0);
    check("t3 overrun pulse", {31'd0, overrun}, 32'd1);
    check("t3 overrun_cnt", {24'd0, overrun_cnt}, 32'd1);
    check("t3 level stays", {29'd0, fifo_level}, 32'd4);
    tick();
    check("t3 overrun one clk", {31'd0, overrun}, 32'd0);
    check("t3 data held", {26'd0, sample_data}, 32'd16);
    for (int k = 0; k < 4; k++) pop_expect($sformatf("t3 drain%0d", k), 6'd16);
    check("t3 drained", {31'd0, sample_valid}, 32'd0);

    // Test 4: full FIFO, pop in the same clk as the window-end push.
    for (int w = 0; w < 4; w++) feed_window(16'hFFFF, 1'b0);
    feed_window(16'h0000, 1'b1);
    check("t4 no overrun", {31'd0, overrun}, 32'd0);
    check("t4 level 4", {29'd0, fifo_level}, 32'd4);
    check("t4 overrun_cnt kept", {24'd0, overrun_cnt}, 32'd1);
    for (int k = 0; k < 3; k++) pop_expect($sformatf("t4 old%0d", k), 6'd16);
    pop_expect("t4 new last", 6'b110000);
    check("t4 drained", {31'd0, sample_valid}, 32'd0);

    // Test 5: drop enable mid-window; strobes while disabled/idle are ignored.
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    enable = 1'b0;
    send_bit(1'b1);
    enable = 1'b1;
    send_bit(1'b1);
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    check("t5 no early sample", {31'd0, sample_valid}, 32'd0);
    send_bit(1'b1);
    check("t5 level", {29'd0, fifo_level}, 32'd1);
    pop_expect("t5 sample", 6'd16);
    check("t5 single sample", {31'd0, sample_valid}, 32'd0);

    // Test 6: reset with samples queued and a half window.
    for (int w = 0; w < 3; w++) feed_window(16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("t6 queued", {29'd0, fifo_level}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6 valid cleared", {31'd0, sample_valid}, 32'd0);
    check("t6 level cleared", {29'd0, fifo_level}, 32'd0);
    check("t6 overrun_cnt cleared", {24'd0, overrun_cnt}, 32'd0);
    check("t6 data cleared", {26'd0, sample_data}, 32'd0);
    tick();
    feed_window(16'hFFF0, 1'b0);
    check("t6 level after window", {29'd0, fifo_level}, 32'd1);
    pop_expect("t6 sample", 6'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
